// File: rtl/rect_fill_plotter.sv
// rect_fill_plotter: latches a rectangle command and sweeps it one pixel per clock onto the DESim VGA plot port.
// Define RECT_FILL_CLIP_EN to suppress plotting of pixels beyond XMAX/YMAX; otherwise coordinates wrap.
module rect_fill_plotter #(
  parameter int XW   = 8,
  parameter int YW   = 7,
  parameter int CW   = 24,
  parameter int XMAX = 159,
  parameter int YMAX = 119
) (
  input  logic          CLOCK_50,
  input  logic          Resetn,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] width,
  input  logic [YW-1:0] height,
  input  logic [CW-1:0] color,
  input  logic          pause,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] VGA_X,
  output logic [YW-1:0] VGA_Y,
  output logic [CW-1:0] VGA_COLOR,
  output logic          plot
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAW, ST_DONE} state_t;

  state_t        state, state_next;
  logic [XW-1:0] cx, cx_next, lx0, lw, base_x, pix_x;
  logic [YW-1:0] cy, cy_next, ly0, lh, base_y, pix_y;
  logic [CW-1:0] lcolor;
  logic          plot_q, accept, load_pix, pix_ok;

  if (YW != XW - 1) begin : g_bad_yw
    $error("rect_fill_plotter: YW must equal XW-1");
  end
  if (XMAX >= 2**XW || YMAX >= 2**YW) begin : g_bad_max
    $error("rect_fill_plotter: XMAX/YMAX exceed coordinate range");
  end

  assign accept = (state == ST_IDLE) && start;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    cx_next    = cx;
    cy_next    = cy;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          cx_next    = '0;
          cy_next    = '0;
          state_next = (width == '0 || height == '0) ? ST_DONE : ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (!pause) begin
          if (cx == lw - 1'b1) begin
            cx_next = '0;
            cy_next = cy + 1'b1;
            if (cy == lh - 1'b1) state_next = ST_DONE;
          end else begin
            cx_next = cx + 1'b1;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // The pixel registered at an edge is the one the counters point to after it;
  // on the accepting edge the origin comes straight from the inputs.
  assign base_x   = accept ? x0 : lx0;
  assign base_y   = accept ? y0 : ly0;
  assign load_pix = (state_next == ST_DRAW) && (accept || !pause);

`ifdef RECT_FILL_CLIP_EN
  localparam logic [XW:0] X_LIM = (XW+1)'(XMAX);
  localparam logic [YW:0] Y_LIM = (YW+1)'(YMAX);
  logic [XW:0] px_wide;
  logic [YW:0] py_wide;

  assign px_wide = {1'b0, base_x} + {1'b0, cx_next};
  assign py_wide = {1'b0, base_y} + {1'b0, cy_next};
  assign pix_x   = px_wide[XW-1:0];
  assign pix_y   = py_wide[YW-1:0];
  assign pix_ok  = (px_wide <= X_LIM) && (py_wide <= Y_LIM);
`else
  assign pix_x  = base_x + cx_next;
  assign pix_y  = base_y + cy_next;
  assign pix_ok = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state     <= ST_IDLE;
      cx        <= '0;
      cy        <= '0;
      lx0       <= '0;
      ly0       <= '0;
      lw        <= '0;
      lh        <= '0;
      lcolor    <= '0;
      VGA_X     <= '0;
      VGA_Y     <= '0;
      VGA_COLOR <= '0;
      plot_q    <= 1'b0;
    end else begin
      state <= state_next;
      cx    <= cx_next;
      cy    <= cy_next;
      if (accept) begin
        lx0    <= x0;
        ly0    <= y0;
        lw     <= width;
        lh     <= height;
        lcolor <= color;
      end
      if (load_pix) begin
        VGA_X     <= pix_x;
        VGA_Y     <= pix_y;
        VGA_COLOR <= accept ? color : lcolor;
        plot_q    <= pix_ok;
      end else if (state_next != ST_DRAW) begin
        plot_q <= 1'b0;
      end
    end
  end

  // Pause gates the registered strobe directly so it bites in the cycle it rises.
  assign plot = plot_q & ~pause;
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_rect_fill_plotter.sv
// tb_rect_fill_plotter: randomized and directed commands checked cycle by cycle against a raster-order pixel model.
module tb_rect_fill_plotter;
  localparam int XW = 8, YW = 7, CW = 24, XMAX = 159, YMAX = 119;

  logic          CLOCK_50 = 1'b0;
  logic          Resetn   = 1'b0;
  logic          start    = 1'b0;
  logic          pause    = 1'b0;
  logic [XW-1:0] x0       = '0;
  logic [YW-1:0] y0       = '0;
  logic [XW-1:0] width    = '0;
  logic [YW-1:0] height   = '0;
  logic [CW-1:0] color    = '0;
  logic          busy, done, plot;
  logic [XW-1:0] VGA_X;
  logic [YW-1:0] VGA_Y;
  logic [CW-1:0] VGA_COLOR;

  int checks = 0;
  int errors = 0;

  rect_fill_plotter #(.XW(XW), .YW(YW), .CW(CW), .XMAX(XMAX), .YMAX(YMAX)) dut (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .start    (start),
    .x0       (x0),
    .y0       (y0),
    .width    (width),
    .height   (height),
    .color    (color),
    .pause    (pause),
    .busy     (busy),
    .done     (done),
    .VGA_X    (VGA_X),
    .VGA_Y    (VGA_Y),
    .VGA_COLOR(VGA_COLOR),
    .plot     (plot)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Command inputs are don't-care outside the accepting edge; stray start pulses must be ignored.
  task automatic scramble();
    x0     = XW'($urandom);
    y0     = YW'($urandom);
    width  = XW'($urandom);
    height = YW'($urandom);
    color  = CW'($urandom);
    start  = ($urandom_range(3) == 0);
  endtask

  task automatic run_cmd(input int ax, input int ay, input int aw, input int ah,
                         input logic [CW-1:0] acol, input bit prand, input logic [31:0] pmask);
    int n, k, c, xs, ys;
    bit vis;
    n = aw * ah;
    k = 0;
    c = 0;
    x0     = XW'(ax);
    y0     = YW'(ay);
    width  = XW'(aw);
    height = YW'(ah);
    color  = acol;
    start  = 1'b1;
    pause  = 1'($urandom);
    @(posedge CLOCK_50);
    #1;
    while (k < n) begin
      c++;
      pause = prand ? ($urandom_range(3) == 0) : ((c < 32) ? pmask[c] : 1'b0);
      scramble();
      @(negedge CLOCK_50);
      xs  = ax + (k % aw);
      ys  = ay + (k / aw);
      vis = 1'b1;
`ifdef RECT_FILL_CLIP_EN
      vis = (xs <= XMAX) && (ys <= YMAX);
`endif
      check("draw_busy", 64'(busy), 64'(1));
      check("draw_done", 64'(done), 64'(0));
      check("draw_plot", 64'(plot), 64'(!pause && vis));
      check("draw_x", 64'(VGA_X), 64'(xs % (1 << XW)));
      check("draw_y", 64'(VGA_Y), 64'(ys % (1 << YW)));
      check("draw_color", 64'(VGA_COLOR), 64'(acol));
      if (!pause) k++;
      @(posedge CLOCK_50);
      #1;
      if (c > n + 400) begin
        check("draw_timeout", 64'(k), 64'(n));
        k = n;
      end
    end
    pause = 1'($urandom);
    scramble();
    @(negedge CLOCK_50);
    check("done_pulse", 64'(done), 64'(1));
    check("done_busy", 64'(busy), 64'(1));
    check("done_plot", 64'(plot), 64'(0));
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
    pause = 1'($urandom);
    @(negedge CLOCK_50);
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_done", 64'(done), 64'(0));
    check("idle_plot", 64'(plot), 64'(0));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_plot"}, 64'(plot), 64'(0));
    check({tag, "_x"}, 64'(VGA_X), 64'(0));
    check({tag, "_y"}, 64'(VGA_Y), 64'(0));
    check({tag, "_color"}, 64'(VGA_COLOR), 64'(0));
  endtask

  initial begin
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check_zero("reset");
    Resetn = 1'b1;
    @(posedge CLOCK_50);
    #1;

    run_cmd(5, 3, 2, 2, 24'hFF0000, 1'b0, 32'h0);
    run_cmd(9, 9, 0, 7, 24'h00FF00, 1'b0, 32'h0);
    run_cmd(9, 9, 3, 0, 24'h0000FF, 1'b0, 32'h0);
    run_cmd(0, 0, 3, 1, 24'h123456, 1'b0, 32'h0000_000C);
    run_cmd(20, 20, 4, 4, 24'hABCDEF, 1'b1, 32'h0);
    run_cmd(158, 0, 4, 1, 24'h777777, 1'b0, 32'h0);
    run_cmd(254, 126, 3, 3, 24'h0F0F0F, 1'b1, 32'h0);

    // Reset in cycle 5 of an 8x8 command must discard it immediately.
    x0 = 8'd10; y0 = 7'd10; width = 8'd8; height = 7'd8; color = 24'hC0FFEE;
    start = 1'b1;
    pause = 1'b0;
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    #1;
    check("pre_reset_plot", 64'(plot), 64'(1));
    Resetn = 1'b0;
    #1;
    check_zero("midreset");
    @(posedge CLOCK_50);
    #1;
    Resetn = 1'b1;
    run_cmd(33, 44, 1, 1, 24'h55AA55, 1'b0, 32'h0);

    for (int i = 0; i < 24; i++) begin
      run_cmd(int'($urandom_range(255)), int'($urandom_range(127)),
              int'($urandom_range(12)), int'($urandom_range(8)),
              CW'($urandom), 1'b1, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
